// File: rtl/mchan_synch_pkg.sv
// ----------------------------------------------------------------------------
// mchan_synch_pkg
// Shared types and constants for the transfer synchronisation logic.
//
// Contents:
//   DEF_SID_WIDTH / DEF_LEN_WIDTH : default mchan field widths
//   cmd_entry_t                   : {sid, len} command queue entry (default widths)
//   PERF_CNT_WIDTH                : width of the optional completed-command counter
//   cmd_entry_pack()              : builds a cmd_entry_t from its fields
// ----------------------------------------------------------------------------
package mchan_synch_pkg;

    localparam int unsigned DEF_SID_WIDTH  = 1;
    localparam int unsigned DEF_LEN_WIDTH  = 8;
    localparam int unsigned PERF_CNT_WIDTH = 16;

    // len is encoded as beats-1, so len=0 is a single-beat command.
    typedef struct packed {
        logic [DEF_SID_WIDTH-1:0] sid;
        logic [DEF_LEN_WIDTH-1:0] len;
    } cmd_entry_t;

    function automatic cmd_entry_t cmd_entry_pack(
        input logic [DEF_SID_WIDTH-1:0] sid,
        input logic [DEF_LEN_WIDTH-1:0] len
    );
        cmd_entry_t e;
        e.sid = sid;
        e.len = len;
        return e;
    endfunction

endpackage

// File: rtl/synch_cmd_fifo.sv
// ----------------------------------------------------------------------------
// synch_cmd_fifo
// Generic synchronous FIFO holding outstanding commands.
//
// Pointers carry one extra wrap bit: equal pointers mean empty, equal index
// with differing wrap bits means full. The head entry is presented
// combinationally (show-ahead). The caller must not push when full; a push
// while full is ignored even if a pop happens in the same cycle.
//
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i, data_i : write request and entry
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : current head entry
//   full_o, empty_o: occupancy flags (from registered pointers)
// ----------------------------------------------------------------------------
module synch_cmd_fifo #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  do_push, do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_o  = mem[rd_ptr[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/cmd_synch_gen.sv
// ----------------------------------------------------------------------------
// cmd_synch_gen
// Release side of the per-SID transfer synchronisation counters. One instance
// tracks the commands issued to a single port/direction, counts completed
// beats against the head command and emits one synch_req_o/synch_sid_o pulse
// per fully completed command (one cycle after its last beat).
//
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   cmd_req_i/gnt_o  : command issue handshake (transfer on req && gnt)
//   cmd_sid_i/len_i  : SID and beats-1 of the issued command
//   beat_valid_i     : one beat of the head command completed
//   synch_req_o      : single-cycle completion pulse
//   synch_sid_o      : SID of the completed command (held between pulses)
//   busy_o           : commands outstanding or completion pulse in flight
//   orphan_beat_o    : sticky, beat seen while no command was queued
//   perf_cmd_cnt_o   : (CMD_SYNCH_GEN_PERF_EN) completed-command count, wraps
//   perf_stall_o     : (CMD_SYNCH_GEN_PERF_EN) request stalled by a full queue
//
// Optional feature macro: CMD_SYNCH_GEN_PERF_EN
// ----------------------------------------------------------------------------
module cmd_synch_gen
    import mchan_synch_pkg::*;
#(
    parameter int unsigned TRANS_SID_WIDTH = DEF_SID_WIDTH,
    parameter int unsigned BEAT_LEN_WIDTH  = DEF_LEN_WIDTH,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_req_i,
    output logic                       cmd_gnt_o,
    input  logic [TRANS_SID_WIDTH-1:0] cmd_sid_i,
    input  logic [BEAT_LEN_WIDTH-1:0]  cmd_len_i,
    input  logic                       beat_valid_i,
    output logic                       synch_req_o,
    output logic [TRANS_SID_WIDTH-1:0] synch_sid_o,
    output logic                       busy_o,
`ifdef CMD_SYNCH_GEN_PERF_EN
    output logic [PERF_CNT_WIDTH-1:0]  perf_cmd_cnt_o,
    output logic                       perf_stall_o,
`endif
    output logic                       orphan_beat_o
);

    // Entry layout follows cmd_entry_t but tracks this instance's widths.
    typedef struct packed {
        logic [TRANS_SID_WIDTH-1:0] sid;
        logic [BEAT_LEN_WIDTH-1:0]  len;
    } entry_t;

    entry_t                    push_entry, head;
    logic                      fifo_full, fifo_empty;
    logic                      push, beat_ok, last_beat;
    logic [BEAT_LEN_WIDTH-1:0] cnt;

    assign push_entry.sid = cmd_sid_i;
    assign push_entry.len = cmd_len_i;

    assign cmd_gnt_o = !fifo_full;
    assign push      = cmd_req_i && cmd_gnt_o;

    // The head is only valid once the FIFO was non-empty at the clock edge,
    // so a beat arriving alongside a push into an empty queue is an orphan.
    assign beat_ok   = beat_valid_i && !fifo_empty;
    assign last_beat = beat_ok && (cnt == head.len);

    synch_cmd_fifo #(
        .DATA_WIDTH ($bits(entry_t)),
        .DEPTH      (FIFO_DEPTH)
    ) i_cmd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (last_beat),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Beat counter: only ever returns to 0 through a last beat, so it can
    // never run past the head length.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (last_beat) begin
            cnt <= '0;
        end else if (beat_ok) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Completion pulse; the SID register holds its value between pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            synch_req_o <= 1'b0;
            synch_sid_o <= '0;
        end else begin
            synch_req_o <= last_beat;
            if (last_beat) synch_sid_o <= head.sid;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            orphan_beat_o <= 1'b0;
        end else if (beat_valid_i && fifo_empty) begin
            orphan_beat_o <= 1'b1;
        end
    end

    assign busy_o = !fifo_empty || synch_req_o;

`ifdef CMD_SYNCH_GEN_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cmd_cnt_o <= '0;
        end else if (synch_req_o) begin
            perf_cmd_cnt_o <= perf_cmd_cnt_o + 1'b1;
        end
    end

    assign perf_stall_o = cmd_req_i && !cmd_gnt_o;
`endif

endmodule

// File: doc/cmd_synch_gen.md
Name: cmd_synch_gen

Overview:
- Release-side companion of the per-SID transfer synchronisation counters.
- Tracks commands issued to one port (TCDM or EXT, one direction); one instance per port/direction.
- Counts completed beats on that port and emits one synch_req/sid pulse per finished command.
- The downstream SID counters decrement on these pulses; they are the *_synch_req_i / *_synch_sid_i inputs of those counters.

Parameters:
- TRANS_SID_WIDTH, 1, width of transfer SID field.
- BEAT_LEN_WIDTH, 8, width of per-command beat length field (encoded beats-1).
- FIFO_DEPTH, 4, outstanding command slots; power of two, >=2.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- cmd_req_i  in  1  command issue request.
- cmd_gnt_o  out  1  command accepted; transfer occurs when cmd_req_i && cmd_gnt_o.
- cmd_sid_i  in  TRANS_SID_WIDTH  SID of issued command.
- cmd_len_i  in  BEAT_LEN_WIDTH  beats-1 of issued command.
- beat_valid_i  in  1  one beat of the head command completed this cycle.
- synch_req_o  out  1  single-cycle pulse: head command fully completed.
- synch_sid_o  out  TRANS_SID_WIDTH  SID qualifying synch_req_o.
- busy_o  out  1  any command outstanding.
- orphan_beat_o  out  1  sticky error: beat_valid_i seen with no outstanding command.

Behaviour:
- Reset: FIFO empty, beat counter 0, synch_req_o=0, synch_sid_o=0, busy_o=0, orphan_beat_o=0, cmd_gnt_o=1.
- FIFO: stores {sid,len}. Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit. Full is defined by the wrap bit, empty by pointer equality.
- cmd_gnt_o = !full (combinational from registered pointers). No push-through when full, even if a pop occurs in the same cycle.
- Beat counter: BEAT_LEN_WIDTH bits. It increments on beat_valid_i while the FIFO is non-empty.
- Last beat: beat_valid_i && !empty && cnt == head.len. On a last beat:
  - pop the head;
  - clear cnt to 0;
  - register synch_req_o=1 and synch_sid_o=head.sid for the next cycle (latency 1).
- synch_req_o is 0 in every cycle that did not follow a last beat. synch_sid_o holds its last value when synch_req_o=0.
- len=0 command: completes on its first beat. Back-to-back single-beat commands give synch_req_o high on consecutive cycles, each with its own SID.
- Push and pop in the same cycle: both performed; the occupancy count is unchanged.
- Push into an empty FIFO with beat_valid_i in the same cycle: the beat is treated as orphan (head not yet valid). orphan_beat_o is set, the beat is dropped and the FIFO still accepts the command.
- orphan_beat_o: once set, it is cleared only by reset.
- busy_o = !empty || synch_req_o. It therefore stays high through the final pulse cycle.
- cnt wraps only by the reset-to-0 on a last beat. cnt never exceeds head.len.
- Reset mid-operation: all state is discarded immediately; no synch pulse is produced for flushed commands.

Optional Feature:
- Macro: CMD_SYNCH_GEN_PERF_EN.
- Defined:
  - adds output perf_cmd_cnt_o (16 bits), a free-running count of synch_req_o pulses;
  - resets to 0 and wraps at 0xFFFF -> 0;
  - adds output perf_stall_o, high when cmd_req_i && !cmd_gnt_o.
- Undefined: both ports and the counter are absent. Core behaviour is identical.

Decomposition:
- Shared package mchan_synch_pkg:
  - typedef cmd_entry_t {sid, len}, parameterised through package-level widths matching the mchan defaults;
  - constant PERF_CNT_WIDTH=16.
- One sub-module: synch_cmd_fifo.
  - Generic sync FIFO: push/pop/full/empty/head data.
  - Instantiated once for the command queue.
- Beat counter and pulse register stay in the top module.

Test Plan:
- Single command sid=1, len=3, then 4 beats on consecutive cycles -> synch_req_o=1, synch_sid_o=1 exactly one cycle after the 4th beat; busy_o falls the cycle after the pulse.
- Push 4 commands (len=0, sids 0,1,0,1) with no beats -> cmd_gnt_o=0 on the 5th request. Then 4 beats -> four consecutive pulses with SIDs 0,1,0,1; gnt returns to 1 after the first pop.
- Command pushed on the same cycle as the last beat of the head with the FIFO at 3/4 -> both operations take effect, occupancy stays 3, next head count starts at 0.
- beat_valid_i with an empty FIFO -> orphan_beat_o=1 and sticky; no synch_req_o. A subsequent len=1 command needs 2 fresh beats.
- Reset asserted after 2 of 5 beats of a len=4 command -> all outputs 0 immediately, no pulse after release. A new len=0 command plus 1 beat -> pulse.
- With CMD_SYNCH_GEN_PERF_EN: 3 completed commands -> perf_cmd_cnt_o=3. Request while full -> perf_stall_o=1 for each stalled cycle.
